// File: rtl/psm_pkg.sv
// Shared constants for the PSM carrier generator and the downstream dead-time stage.
package psm_pkg;
  localparam int BITS_DATA          = 16;
  localparam int DEADTIME_BITS_DATA = 10;
  localparam int PSM_MIN_PERIOD     = 2;
endpackage

// File: rtl/psm_leg_counter.sv
// One leg of the carrier: a loadable mod-P up-counter with a registered (next < H) output.
module psm_leg_counter
  import psm_pkg::*;
#(
  parameter int W = BITS_DATA
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_wrap,
  input  logic [W-1:0] i_half,
  input  logic         i_active,
  output logic [W-1:0] o_cnt,
  output logic         o_out
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;
  logic         r_out;
  logic [W-1:0] w_next;

  always_comb begin
    w_next = r_cnt + ONE;
    if (i_load) w_next = i_load_val;
    else if (i_wrap) w_next = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else begin
      r_cnt <= w_next;
      r_out <= i_active && (w_next < i_half);
    end
  end

  assign o_cnt = r_cnt;
  assign o_out = r_out;
endmodule

// File: rtl/psm_carrier_gen.sv
// 50 % duty PSM carrier: leg A plus a phase-lagged leg B, with period/phase
// shadowed at each period start so reprogramming never produces runt pulses.
module psm_carrier_gen #(
  parameter int BITS_DATA = psm_pkg::BITS_DATA
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 iENABLE,
  input  logic [BITS_DATA-1:0] iFREQUENCY,
  input  logic [BITS_DATA-1:0] iPHASE,
  output logic                 oPSM_A,
  output logic                 oPSM_B,
  output logic                 oSYNC,
  output logic                 oFAULT
);
  import psm_pkg::*;

  localparam logic [BITS_DATA-1:0] MIN_P = BITS_DATA'(PSM_MIN_PERIOD);
  localparam logic [BITS_DATA-1:0] ONE   = BITS_DATA'(1);

  logic [BITS_DATA-1:0] r_p_s;
  logic                 r_run;
  logic                 r_sync;
  logic                 r_fault;

  logic [BITS_DATA-1:0] w_p_m1;
  logic [BITS_DATA-1:0] w_ph_clamp;
  logic                 w_in_legal;
  logic [BITS_DATA-1:0] w_load_b;
  logic [BITS_DATA-1:0] w_cnt_a;
  logic [BITS_DATA-1:0] w_cnt_b;
  logic                 w_wrap_a;
  logic                 w_wrap_b;
  logic                 w_load;
  logic [BITS_DATA-1:0] w_p_next;
  logic [BITS_DATA-1:0] w_h_next;
  logic                 w_active;

  assign w_p_m1     = iFREQUENCY - ONE;
  assign w_ph_clamp = (iPHASE > w_p_m1) ? w_p_m1 : iPHASE;
  assign w_in_legal = (iFREQUENCY >= MIN_P);
  // The phase shadow lives on only as leg B's starting offset, so it is not kept separately.
  assign w_load_b   = (!w_in_legal || (w_ph_clamp == '0)) ? '0 : (iFREQUENCY - w_ph_clamp);

  assign w_wrap_a = (w_cnt_a == (r_p_s - ONE));
  assign w_wrap_b = (w_cnt_b == (r_p_s - ONE));
  assign w_load   = !iENABLE || !r_run || w_wrap_a || (r_p_s < MIN_P);
  assign w_p_next = w_load ? iFREQUENCY : r_p_s;
  assign w_h_next = w_p_next >> 1;
  assign w_active = iENABLE && (w_p_next >= MIN_P);

  psm_leg_counter #(.W(BITS_DATA)) u_leg_a (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_load),
    .i_load_val ('0),
    .i_wrap     (w_wrap_a),
    .i_half     (w_h_next),
    .i_active   (w_active),
    .o_cnt      (w_cnt_a),
    .o_out      (oPSM_A)
  );

  psm_leg_counter #(.W(BITS_DATA)) u_leg_b (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_load),
    .i_load_val (w_load_b),
    .i_wrap     (w_wrap_b),
    .i_half     (w_h_next),
    .i_active   (w_active),
    .o_cnt      (w_cnt_b),
    .o_out      (oPSM_B)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_p_s   <= '0;
      r_run   <= 1'b0;
      r_sync  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      if (w_load) r_p_s <= iFREQUENCY;
      r_run   <= iENABLE;
      r_sync  <= w_active && (w_load || w_wrap_a);
      r_fault <= (w_p_next < MIN_P);
    end
  end

  assign oSYNC  = r_sync;
  assign oFAULT = r_fault;
endmodule

// File: tb/tb_psm_carrier_gen.sv
// Bench for psm_carrier_gen: per-period waveform model in a queue, compared every cycle.
module tb_psm_carrier_gen;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         iENABLE = 1'b0;
  logic [W-1:0] iFREQUENCY = '0;
  logic [W-1:0] iPHASE = '0;
  logic         oPSM_A, oPSM_B, oSYNC, oFAULT;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp_now;
  logic [3:0] got;

  psm_carrier_gen #(.BITS_DATA(W)) dut (
    .CLK(CLK), .RST(RST), .iENABLE(iENABLE), .iFREQUENCY(iFREQUENCY), .iPHASE(iPHASE),
    .oPSM_A(oPSM_A), .oPSM_B(oPSM_B), .oSYNC(oSYNC), .oFAULT(oFAULT)
  );

  always #5 CLK = ~CLK;

  // Whole-period expectation {A,B,SYNC,FAULT}: A high for the first P/2 cycles,
  // B is A delayed by the clamped phase, SYNC on the first cycle.
  task automatic gen_period(input int p, input int ph);
    int ph_c, h;
    logic a, b, s;
    if (p < 2) begin
      exp_q.push_back(4'b0001);
      return;
    end
    ph_c = (ph > p - 1) ? p - 1 : ph;
    h = p / 2;
    for (int t = 0; t < p; t++) begin
      a = (t < h);
      b = (((t - ph_c + p) % p) < h);
      s = (t == 0);
      exp_q.push_back({a, b, s, 1'b0});
    end
  endtask

  task automatic model_step();
    if (RST) begin
      exp_q.delete();
      exp_now = 4'b0000;
    end else if (!iENABLE) begin
      exp_q.delete();
      exp_now = {3'b000, (int'(iFREQUENCY) < 2)};
    end else begin
      if (exp_q.size() == 0) gen_period(int'(iFREQUENCY), int'(iPHASE));
      exp_now = exp_q.pop_front();
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
    got = {oPSM_A, oPSM_B, oSYNC, oFAULT};
  endtask

  task automatic go_idle(input int p, input int ph);
    iENABLE = 1'b0;
    iFREQUENCY = W'(p);
    iPHASE = W'(ph);
    cycle();
    checks++;
    if (got !== exp_now) begin
      errors++;
      $display("FAIL idle got=%b exp=%b t=%0t", got, exp_now, $time);
    end
    iENABLE = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    iENABLE = 1'b1;
    iFREQUENCY = 16'd20;
    #1;
    checks++;
    if ({oPSM_A, oPSM_B, oSYNC, oFAULT} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async got=%b exp=0000", {oPSM_A, oPSM_B, oSYNC, oFAULT});
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (got !== exp_now) begin
        errors++;
        $display("FAIL reset got=%b exp=%b t=%0t", got, exp_now, $time);
      end
    end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    go_idle(20, 0);
    for (int i = 0; i < 60; i++) begin
      cycle();
      checks++;
      if (got !== exp_now) begin
        errors++;
        $display("FAIL basic_p20 got=%b exp=%b t=%0t", got, exp_now, $time);
      end
    end
  endtask

  task automatic test_phase();
    go_idle(20, 5);
    for (int i = 0; i < 60; i++) begin
      cycle();
      checks++;
      if (got !== exp_now) begin
        errors++;
        $display("FAIL phase_p20_ph5 got=%b exp=%b t=%0t", got, exp_now, $time);
      end
    end
  endtask

  task automatic test_clamp();
    go_idle(7, 9);
    for (int i = 0; i < 35; i++) begin
      cycle();
      checks++;
      if (got !== exp_now) begin
        errors++;
        $display("FAIL clamp_p7_ph9 got=%b exp=%b t=%0t", got, exp_now, $time);
      end
    end
  endtask

  task automatic test_reprogram();
    go_idle(20, 3);
    for (int i = 0; i < 55; i++) begin
      if (i == 5) begin
        iFREQUENCY = 16'd12;
        iPHASE = 16'd4;
      end
      cycle();
      checks++;
      if (got !== exp_now) begin
        errors++;
        $display("FAIL reprogram got=%b exp=%b t=%0t", got, exp_now, $time);
      end
    end
  endtask

  task automatic test_fault();
    go_idle(1, 0);
    for (int i = 0; i < 30; i++) begin
      if (i == 10) iFREQUENCY = 16'd4;
      cycle();
      checks++;
      if (got !== exp_now) begin
        errors++;
        $display("FAIL fault_recover got=%b exp=%b t=%0t", got, exp_now, $time);
      end
    end
  endtask

  task automatic test_disable_mid();
    go_idle(10, 2);
    for (int i = 0; i < 30; i++) begin
      iENABLE = !(i == 7 || i == 8);
      cycle();
      checks++;
      if (got !== exp_now) begin
        errors++;
        $display("FAIL disable_mid got=%b exp=%b t=%0t", got, exp_now, $time);
      end
    end
  endtask

  task automatic test_reset_mid();
    go_idle(20, 0);
    for (int i = 0; i < 5; i++) cycle();
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({oPSM_A, oPSM_B, oSYNC, oFAULT} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_async got=%b exp=0000", {oPSM_A, oPSM_B, oSYNC, oFAULT});
    end
    cycle();
    RST = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      checks++;
      if (got !== exp_now) begin
        errors++;
        $display("FAIL reset_mid_restart got=%b exp=%b t=%0t", got, exp_now, $time);
      end
    end
  endtask

  task automatic test_random();
    go_idle(10, 3);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) iENABLE = ~iENABLE;
      if ($urandom_range(0, 29) == 0) iFREQUENCY = W'($urandom_range(0, 40));
      if ($urandom_range(0, 29) == 0) iPHASE = W'($urandom_range(0, 45));
      cycle();
      checks++;
      if (got !== exp_now) begin
        errors++;
        $display("FAIL random got=%b exp=%b F=%0d PH=%0d en=%b t=%0t",
                 got, exp_now, iFREQUENCY, iPHASE, iENABLE, $time);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_phase();
    test_clamp();
    test_reprogram();
    test_fault();
    test_disable_mid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
